// File: rtl/pid_loop_sequencer_if.sv
// Sensor sample handshake between the loop sequencer (master) and the sensor front end (slave).
interface pid_loop_sequencer_if;
    logic        samp_req;
    logic        samp_ack;
    logic [15:0] samp_data;

    modport master (output samp_req, input samp_ack, input samp_data);
    modport slave  (input samp_req, output samp_ack, output samp_data);
endinterface

// File: rtl/pid_loop_sequencer.sv
// Control-period sequencer for one PID loop: period tick, sample handshake, engine strobe,
// actuator latch, atomic gain/setpoint commit and fault handling.
module pid_loop_sequencer #(
    parameter int PERIOD_W   = 24,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    pid_loop_sequencer_if.master samp_if,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [15:0]         timeout_i,
    input  logic                cfg_we_i,
    input  logic [2:0]          cfg_addr_i,
    input  logic [15:0]         cfg_data_i,
    output logic [15:0]         kp_n_o,
    output logic [15:0]         kp_ds_o,
    output logic [15:0]         ki_n_o,
    output logic [15:0]         ki_ds_o,
    output logic [15:0]         kd_n_o,
    output logic [15:0]         kd_ds_o,
    output logic [15:0]         setpoint_o,
    output logic [15:0]         observed_o,
    output logic                pid_rst_o,
    output logic                pid_step_o,
    input  logic [15:0]         pid_out_i,
    output logic [15:0]         act_out_o,
    output logic                act_valid_o,
    output logic                fault_o,
    output logic                overrun_o
);

    localparam int SETTLE_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        REQ,
        STEP,
        SETTLE,
        FAULT
    } state_e;

    state_e               state_q, state_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [15:0]          wait_q, wait_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [6:0][15:0]     shadow_q, shadow_d;
    logic [6:0][15:0]     active_q, active_d;
    logic                 pending_q, pending_d;
    logic [15:0]          observed_q, observed_d;
    logic [15:0]          act_out_q, act_out_d;
    logic                 act_valid_q, act_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 samp_req_q, pid_step_q, fault_q, pid_rst_q;

    logic [PERIOD_W-1:0]  eff_period;
    logic                 running;
    logic                 tick;
    logic                 commit_wr;

    assign eff_period = (period_i < PERIOD_W'(4)) ? PERIOD_W'(4) : period_i;
    assign running    = (state_q == WAIT_TICK) || (state_q == REQ) ||
                        (state_q == STEP) || (state_q == SETTLE);
    // >= rather than == so a period shortened mid-count still wraps promptly.
    assign tick       = running && (cnt_q >= (eff_period - PERIOD_W'(1)));
    assign commit_wr  = cfg_we_i && (cfg_addr_i == 3'd7);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        settle_d    = settle_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        pending_d   = pending_q | commit_wr;
        observed_d  = observed_q;
        act_out_d   = act_out_q;
        act_valid_d = 1'b0;
        overrun_d   = overrun_q;

        for (int i = 0; i < 7; i++) begin
            if (cfg_we_i && (cfg_addr_i == 3'(i))) begin
                shadow_d[i] = cfg_data_i;
            end
        end

        if (running) begin
            cnt_d = tick ? '0 : cnt_q + PERIOD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = WAIT_TICK;
                    cnt_d   = '0;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    // Same-cycle writes are folded into the commit via shadow_d.
                    if (pending_q || commit_wr) begin
                        active_d  = shadow_d;
                        pending_d = 1'b0;
                    end
                    state_d = REQ;
                    wait_d  = '0;
                end
            end
            REQ: begin
                if (samp_if.samp_ack) begin
                    observed_d = samp_if.samp_data;
                    state_d    = STEP;
                end else if ((timeout_i != 16'd0) &&
                             (({1'b0, wait_q} + 17'd1) == {1'b0, timeout_i})) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            STEP: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    act_out_d   = pid_out_i;
                    act_valid_d = 1'b1;
                    state_d     = WAIT_TICK;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tick && (state_q != WAIT_TICK)) begin
            overrun_d = 1'b1;
        end

        // Dropping enable aborts everything but keeps shadow regs and any pending commit.
        if (!enable_i) begin
            state_d     = IDLE;
            active_d    = active_q;
            pending_d   = pending_q | commit_wr;
            observed_d  = observed_q;
            act_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if ((state_d == IDLE) || (state_d == FAULT)) begin
            act_out_d = '0;
        end
    end

    // All handshake/strobe outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            settle_q    <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            observed_q  <= '0;
            act_out_q   <= '0;
            act_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            samp_req_q  <= 1'b0;
            pid_step_q  <= 1'b0;
            fault_q     <= 1'b0;
            pid_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            settle_q    <= settle_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            observed_q  <= observed_d;
            act_out_q   <= act_out_d;
            act_valid_q <= act_valid_d;
            overrun_q   <= overrun_d;
            samp_req_q  <= (state_d == REQ);
            pid_step_q  <= (state_d == STEP);
            fault_q     <= (state_d == FAULT);
            pid_rst_q   <= (state_d == IDLE) || (state_d == FAULT) ||
                           ((state_q == IDLE) && (state_d == WAIT_TICK));
        end
    end

    assign samp_if.samp_req = samp_req_q;
    assign kp_n_o      = active_q[0];
    assign kp_ds_o     = active_q[1];
    assign ki_n_o      = active_q[2];
    assign ki_ds_o     = active_q[3];
    assign kd_n_o      = active_q[4];
    assign kd_ds_o     = active_q[5];
    assign setpoint_o  = active_q[6];
    assign observed_o  = observed_q;
    assign pid_rst_o   = pid_rst_q;
    assign pid_step_o  = pid_step_q;
    assign act_out_o   = act_out_q;
    assign act_valid_o = act_valid_q;
    assign fault_o     = fault_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench for pid_loop_sequencer: cycle-exact checks of tick, handshake, commit,
// timeout fault, overrun, enable drop and reset behaviour.
module tb_pid_loop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] period;
    logic [15:0] timeout;
    logic        cfgWe;
    logic [2:0]  cfgAddr;
    logic [15:0] cfgData;
    logic [15:0] kpN, kpDs, kiN, kiDs, kdN, kdDs, setpoint, observed;
    logic        pidRst, pidStep, actValid, fault, overrun;
    logic [15:0] pidOut, actOut;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    pid_loop_sequencer_if sampIf ();

    pid_loop_sequencer #(.PERIOD_W(24), .SETTLE_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .samp_if     (sampIf),
        .enable_i    (enable),
        .period_i    (period),
        .timeout_i   (timeout),
        .cfg_we_i    (cfgWe),
        .cfg_addr_i  (cfgAddr),
        .cfg_data_i  (cfgData),
        .kp_n_o      (kpN),
        .kp_ds_o     (kpDs),
        .ki_n_o      (kiN),
        .ki_ds_o     (kiDs),
        .kd_n_o      (kdN),
        .kd_ds_o     (kdDs),
        .setpoint_o  (setpoint),
        .observed_o  (observed),
        .pid_rst_o   (pidRst),
        .pid_step_o  (pidStep),
        .pid_out_i   (pidOut),
        .act_out_o   (actOut),
        .act_valid_o (actValid),
        .fault_o     (fault),
        .overrun_o   (overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) step();
    endtask

    task automatic applyStimulus(input logic en, input logic [23:0] per, input logic [15:0] tmo);
        enable  = en;
        period  = per;
        timeout = tmo;
    endtask

    task automatic doReset();
        rst             = 1'b1;
        enable          = 1'b0;
        cfgWe           = 1'b0;
        cfgAddr         = 3'd0;
        cfgData         = 16'd0;
        sampIf.samp_ack = 1'b0;
        sampIf.samp_data = 16'd0;
        pidOut          = 16'd0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic setCfg(input logic we, input logic [2:0] addr, input logic [15:0] data);
        cfgWe   = we;
        cfgAddr = addr;
        cfgData = data;
    endtask

    initial begin
        period  = 24'd10;
        timeout = 16'd0;
        doReset();
        checkOutput("rst_samp_req", sampIf.samp_req, 0);
        checkOutput("rst_pid_rst", pidRst, 1);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_act_out", actOut, 0);
        checkOutput("rst_kp_n", kpN, 0);

        // Nominal period, then timeout fault on the following request.
        applyStimulus(1'b1, 24'd10, 16'd0);
        pidOut = 16'd1234;
        runTo(1);  checkOutput("t1_pid_rst_first", pidRst, 1);
        runTo(2);  checkOutput("t1_pid_rst_run", pidRst, 0);
        runTo(10); checkOutput("t1_req_before", sampIf.samp_req, 0);
        runTo(11); checkOutput("t1_req_rise", sampIf.samp_req, 1);
        runTo(13);
        sampIf.samp_ack  = 1'b1;
        sampIf.samp_data = 16'h0123;
        step();
        sampIf.samp_ack = 1'b0;
        checkOutput("t1_pid_step", pidStep, 1);
        checkOutput("t1_req_drop", sampIf.samp_req, 0);
        checkOutput("t1_observed", observed, 16'h0123);
        runTo(16); checkOutput("t1_valid_early", actValid, 0);
        checkOutput("t1_step_once", pidStep, 0);
        runTo(17); checkOutput("t1_act_out", actOut, 16'd1234);
        checkOutput("t1_act_valid", actValid, 1);
        applyStimulus(1'b1, 24'd10, 16'd5);
        runTo(18); checkOutput("t1_valid_pulse", actValid, 0);
        checkOutput("t1_act_hold", actOut, 16'd1234);
        runTo(20); checkOutput("t1_req2_before", sampIf.samp_req, 0);
        runTo(21); checkOutput("t1_req2_rise", sampIf.samp_req, 1);
        runTo(25); checkOutput("t2_req_last", sampIf.samp_req, 1);
        checkOutput("t2_fault_early", fault, 0);
        runTo(26); checkOutput("t2_fault", fault, 1);
        checkOutput("t2_req_off", sampIf.samp_req, 0);
        checkOutput("t2_act_zero", actOut, 0);
        checkOutput("t2_pid_rst", pidRst, 1);
        runTo(27); checkOutput("t2_fault_hold", fault, 1);
        enable = 1'b0;
        step();
        checkOutput("t2_fault_clear", fault, 0);
        checkOutput("t2_idle_pid_rst", pidRst, 1);

        // Shadow write, commit, late write before tick; commit in the tick cycle.
        doReset();
        applyStimulus(1'b1, 24'd10, 16'd0);
        pidOut = 16'hFF00;
        runTo(3);
        setCfg(1'b1, 3'd0, 16'h0100); step();
        setCfg(1'b1, 3'd7, 16'hDEAD); step();
        setCfg(1'b1, 3'd0, 16'h0200); step();
        setCfg(1'b0, 3'd0, 16'h0000);
        runTo(10); checkOutput("t3_kp_at_tick", kpN, 0);
        runTo(11); checkOutput("t3_kp_after_tick", kpN, 16'h0200);
        runTo(12);
        sampIf.samp_ack  = 1'b1;
        sampIf.samp_data = 16'h7FFF;
        step();
        sampIf.samp_ack = 1'b0;
        checkOutput("t3_pid_step", pidStep, 1);
        runTo(16); checkOutput("t3_act_neg", actOut, 16'hFF00);
        checkOutput("t3_act_valid", actValid, 1);
        runTo(17);
        setCfg(1'b1, 3'd4, 16'h0005); step();
        setCfg(1'b0, 3'd0, 16'h0000);
        runTo(21); checkOutput("t3_kd_uncommitted", kdN, 0);
        runTo(22);
        sampIf.samp_ack = 1'b1;
        step();
        sampIf.samp_ack = 1'b0;
        runTo(30);
        setCfg(1'b1, 3'd7, 16'h0000); step();
        setCfg(1'b0, 3'd0, 16'h0000);
        checkOutput("t3_kd_tick_commit", kdN, 16'h0005);
        checkOutput("t3_kp_retained", kpN, 16'h0200);

        // Period below minimum with slow ack: overrun, no extra request, then enable drop.
        doReset();
        applyStimulus(1'b1, 24'd2, 16'd0);
        pidOut = 16'h0042;
        runTo(4);  checkOutput("t4_req_before", sampIf.samp_req, 0);
        runTo(5);  checkOutput("t4_req_rise", sampIf.samp_req, 1);
        runTo(8);  checkOutput("t4_overrun_early", overrun, 0);
        runTo(9);  checkOutput("t4_overrun_set", overrun, 1);
        checkOutput("t4_req_held", sampIf.samp_req, 1);
        runTo(11);
        sampIf.samp_ack = 1'b1;
        step();
        sampIf.samp_ack = 1'b0;
        checkOutput("t4_pid_step", pidStep, 1);
        checkOutput("t4_req_drop", sampIf.samp_req, 0);
        runTo(13); checkOutput("t4_no_extra_req", sampIf.samp_req, 0);
        runTo(15); checkOutput("t4_act_valid", actValid, 1);
        checkOutput("t4_act_out", actOut, 16'h0042);
        runTo(16); checkOutput("t4_req_wait", sampIf.samp_req, 0);
        runTo(17); checkOutput("t4_req_next", sampIf.samp_req, 1);
        checkOutput("t4_overrun_sticky", overrun, 1);
        enable = 1'b0;
        step();
        checkOutput("t5_req_off", sampIf.samp_req, 0);
        checkOutput("t5_act_zero", actOut, 0);
        checkOutput("t5_overrun_clr", overrun, 0);
        checkOutput("t5_pid_rst", pidRst, 1);

        // Synchronous reset in the last SETTLE cycle.
        doReset();
        applyStimulus(1'b1, 24'd10, 16'd0);
        pidOut = 16'h1111;
        runTo(2);
        setCfg(1'b1, 3'd0, 16'h0007); step();
        setCfg(1'b1, 3'd7, 16'h0000); step();
        setCfg(1'b0, 3'd0, 16'h0000);
        runTo(11); checkOutput("t6_kp_committed", kpN, 16'h0007);
        runTo(12);
        sampIf.samp_ack  = 1'b1;
        sampIf.samp_data = 16'h0055;
        step();
        sampIf.samp_ack = 1'b0;
        runTo(15); checkOutput("t6_observed", observed, 16'h0055);
        rst = 1'b1;
        step();
        checkOutput("t6_no_valid", actValid, 0);
        checkOutput("t6_act_zero", actOut, 0);
        checkOutput("t6_kp_zero", kpN, 0);
        checkOutput("t6_obs_zero", observed, 0);
        checkOutput("t6_pid_rst", pidRst, 1);
        rst = 1'b0;
        step();
        checkOutput("t6_still_no_valid", actValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
